// File: rtl/ec_seq_pkg.sv
// Shared types for the erasure-coding stripe sequencer: FSM states, the latched
// job configuration and the default geometry constants.
package ec_seq_pkg;

  localparam int EC_K_MAX       = 8;
  localparam int EC_M_MAX       = 4;
  localparam int EC_ADDR_W      = 32;
  localparam int EC_CHUNK_BYTES = 64;
  localparam int EC_STRIPE_W    = 16;
  localparam int EC_K_W         = $clog2(EC_K_MAX + 1);
  localparam int EC_M_W         = $clog2(EC_M_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CALC  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_STORE = 3'd5,
    ST_NEXT  = 3'd6,
    ST_DONE  = 3'd7
  } ec_state_e;

  typedef struct packed {
    logic [EC_K_W-1:0]      k;
    logic [EC_M_W-1:0]      m;
    logic [EC_STRIPE_W-1:0] stripes;
    logic [EC_ADDR_W-1:0]   data_base;
    logic [EC_ADDR_W-1:0]   par_base;
  } ec_job_cfg_t;

  // k and m must each be non-zero and within the engine's chunk capacity
  function automatic logic cfg_legal(input ec_job_cfg_t c, input int k_max, input int m_max);
    return (c.k != EC_K_W'(0)) && (int'(c.k) <= k_max) &&
           (c.m != EC_M_W'(0)) && (int'(c.m) <= m_max);
  endfunction

endpackage

// File: rtl/ec_addr_ptr.sv
// Running chunk address pointer: loads a base, then steps by one chunk per
// handshake, wrapping modulo 2^ADDR_W.
module ec_addr_ptr #(
  parameter int ADDR_W = 32,
  parameter int STEP   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // next pointer value: load wins over increment
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (inc_i) begin
      addr_d = addr_q + ADDR_W'(STEP);
    end else begin
      addr_d = addr_q;
    end
  end

  // pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/ec_stripe_sequencer.sv
// Erasure-coding job sequencer: per stripe reads k chunks, kicks one parity
// calculation, writes m parity chunks. Optional cycle counter: EC_SEQ_PERF_EN.
module ec_stripe_sequencer
  import ec_seq_pkg::*;
#(
  parameter int K_MAX       = EC_K_MAX,
  parameter int M_MAX       = EC_M_MAX,
  parameter int ADDR_W      = EC_ADDR_W,
  parameter int CHUNK_BYTES = EC_CHUNK_BYTES,
  parameter int STRIPE_W    = EC_STRIPE_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(K_MAX+1)-1:0]   cfg_k,
  input  logic [$clog2(M_MAX+1)-1:0]   cfg_m,
  input  logic [STRIPE_W-1:0]          cfg_stripes,
  input  logic [ADDR_W-1:0]            cfg_data_base,
  input  logic [ADDR_W-1:0]            cfg_par_base,
  output logic                         busy,
  output logic                         finish,
  output logic                         err,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [ADDR_W-1:0]            rd_addr,
  output logic [$clog2(K_MAX)-1:0]     rd_idx,
  output logic                         calc_start,
  input  logic                         calc_done,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [$clog2(M_MAX)-1:0]     wr_idx,
  output logic [31:0]                  perf_cycles
);

  localparam int KW  = $clog2(K_MAX + 1);
  localparam int MW  = $clog2(M_MAX + 1);
  localparam int KIW = $clog2(K_MAX);
  localparam int MIW = $clog2(M_MAX);

  ec_state_e           state_q, state_d;
  ec_job_cfg_t         cfg_q, cfg_d;
  logic [STRIPE_W-1:0] stripe_q, stripe_d;
  logic [KIW-1:0]      rd_idx_q, rd_idx_d;
  logic [MIW-1:0]      wr_idx_q, wr_idx_d;
  logic                err_d;
  logic                busy_q, finish_q, err_q, rd_valid_q, wr_valid_q, calc_start_q;
  logic                accept_s, rd_hs_s, wr_hs_s, last_rd_s, last_wr_s;

  assign accept_s  = (state_q == ST_IDLE) && start;
  assign rd_hs_s   = rd_valid_q && rd_ready;
  assign wr_hs_s   = wr_valid_q && wr_ready;
  assign last_rd_s = (KW'(rd_idx_q) + KW'(1)) == cfg_q.k;
  assign last_wr_s = (MW'(wr_idx_q) + MW'(1)) == cfg_q.m;

  // next-state, configuration latch and index/stripe counters
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    stripe_d = stripe_q;
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d = '{k: cfg_k, m: cfg_m, stripes: cfg_stripes,
                    data_base: cfg_data_base, par_base: cfg_par_base};
          stripe_d = '0;
          rd_idx_d = '0;
          wr_idx_d = '0;
          state_d  = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (!cfg_legal(cfg_q, K_MAX, M_MAX)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (cfg_q.stripes == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (rd_hs_s && last_rd_s) begin
          rd_idx_d = '0;
          state_d  = ST_CALC;
        end else if (rd_hs_s) begin
          rd_idx_d = rd_idx_q + KIW'(1);
        end else begin
          rd_idx_d = rd_idx_q;
        end
      end
      ST_CALC: state_d = ST_WAIT;
      ST_WAIT: begin
        if (calc_done) begin
          state_d = ST_STORE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_STORE: begin
        if (wr_hs_s && last_wr_s) begin
          wr_idx_d = '0;
          state_d  = ST_NEXT;
        end else if (wr_hs_s) begin
          wr_idx_d = wr_idx_q + MIW'(1);
        end else begin
          wr_idx_d = wr_idx_q;
        end
      end
      ST_NEXT: begin
        stripe_d = stripe_q + STRIPE_W'(1);
        if (stripe_d == cfg_q.stripes) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state, job registers and outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      stripe_q     <= '0;
      rd_idx_q     <= '0;
      wr_idx_q     <= '0;
      busy_q       <= 1'b0;
      finish_q     <= 1'b0;
      err_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      wr_valid_q   <= 1'b0;
      calc_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      stripe_q     <= stripe_d;
      rd_idx_q     <= rd_idx_d;
      wr_idx_q     <= wr_idx_d;
      busy_q       <= (state_d != ST_IDLE);
      finish_q     <= (state_d == ST_DONE);
      err_q        <= err_d;
      rd_valid_q   <= (state_d == ST_LOAD);
      wr_valid_q   <= (state_d == ST_STORE);
      calc_start_q <= (state_d == ST_CALC);
    end
  end

  ec_addr_ptr #(.ADDR_W(ADDR_W), .STEP(CHUNK_BYTES)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .load_i(accept_s), .load_val_i(cfg_data_base),
    .inc_i(rd_hs_s), .addr_o(rd_addr)
  );

  ec_addr_ptr #(.ADDR_W(ADDR_W), .STEP(CHUNK_BYTES)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .load_i(accept_s), .load_val_i(cfg_par_base),
    .inc_i(wr_hs_s), .addr_o(wr_addr)
  );

  assign busy       = busy_q;
  assign finish     = finish_q;
  assign err        = err_q;
  assign rd_valid   = rd_valid_q;
  assign wr_valid   = wr_valid_q;
  assign calc_start = calc_start_q;
  assign rd_idx     = rd_idx_q;
  assign wr_idx     = wr_idx_q;

`ifdef EC_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  // cleared on accept, counts busy cycles, holds after the job ends
  always_comb begin
    perf_d = perf_q;
    if (accept_s) begin
      perf_d = 32'd0;
    end else if (busy_q) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // cycle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ec_stripe_sequencer.sv
// Directed, table-driven bench for ec_stripe_sequencer with an address model,
// a small engine model for calc_done and a reset-during-WAIT sequence.
module tb_ec_stripe_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, rd_ready, calc_done, wr_ready;
  logic [3:0]  cfg_k;
  logic [2:0]  cfg_m;
  logic [15:0] cfg_stripes;
  logic [31:0] cfg_data_base, cfg_par_base;
  logic        busy, finish, err, rd_valid, calc_start, wr_valid;
  logic [31:0] rd_addr, wr_addr, perf_cycles;
  logic [2:0]  rd_idx;
  logic [1:0]  wr_idx;

  always #5 clk = ~clk;

  ec_stripe_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_m(cfg_m),
    .cfg_stripes(cfg_stripes), .cfg_data_base(cfg_data_base), .cfg_par_base(cfg_par_base),
    .busy(busy), .finish(finish), .err(err), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr(rd_addr), .rd_idx(rd_idx), .calc_start(calc_start), .calc_done(calc_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_idx(wr_idx),
    .perf_cycles(perf_cycles)
  );

  typedef struct {
    int          k;
    int          m;
    int          stripes;
    logic [31:0] db;
    logic [31:0] pb;
    int          w;
    bit          stall;
    bit          hold_start;
    int          exp_fin;
    bit          exp_err;
    int          exp_rd;
    int          exp_wr;
    int          exp_calc;
  } vec_t;

  vec_t vecs[11];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v, input int vi);
    int cyc, fin_cyc, rd_n, wr_n, calc_n, rd_s, rd_i, wr_s, wr_j, wcnt;
    bit seen_fin, fin_err, overlap_bad, busy_bad, order_bad;
    logic [31:0] exp_a;
    cyc = 0; fin_cyc = 0; rd_n = 0; wr_n = 0; calc_n = 0;
    rd_s = 0; rd_i = 0; wr_s = 0; wr_j = 0; wcnt = 0;
    seen_fin = 0; fin_err = 0; overlap_bad = 0; busy_bad = 0; order_bad = 0;
    cfg_k = 4'(v.k); cfg_m = 3'(v.m); cfg_stripes = 16'(v.stripes);
    cfg_data_base = v.db; cfg_par_base = v.pb;
    start = 1'b1; calc_done = 1'b0; rd_ready = 1'b1; wr_ready = 1'b1;
    while (!seen_fin && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (!v.hold_start) start = 1'b0;
      calc_done = 1'b0;
      if (rd_valid && wr_valid) overlap_bad = 1;
      if (!busy) busy_bad = 1;
      if (rd_valid) begin
        exp_a = v.db + 32'((rd_s * v.k + rd_i) * 64);
        chk($sformatf("v%0d rd_addr", vi), 64'(rd_addr), 64'(exp_a));
        chk($sformatf("v%0d rd_idx", vi), 64'(rd_idx), 64'(rd_i));
      end
      if (wr_valid) begin
        exp_a = v.pb + 32'((wr_s * v.m + wr_j) * 64);
        chk($sformatf("v%0d wr_addr", vi), 64'(wr_addr), 64'(exp_a));
        chk($sformatf("v%0d wr_idx", vi), 64'(wr_idx), 64'(wr_j));
      end
      if (calc_start) begin
        if (rd_n != v.k * (calc_n + 1) || wr_n != v.m * calc_n) order_bad = 1;
        calc_n++;
        wcnt = v.w;
      end else if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) calc_done = 1'b1;
      end
      if (finish) begin
        seen_fin = 1; fin_cyc = cyc; fin_err = err; start = 1'b0;
      end
      rd_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid && rd_ready) begin
        rd_n++; rd_i++;
        if (rd_i == v.k) begin rd_i = 0; rd_s++; end
      end
      if (wr_valid && wr_ready) begin
        wr_n++; wr_j++;
        if (wr_j == v.m) begin wr_j = 0; wr_s++; end
      end
    end
    chk($sformatf("v%0d finish_seen", vi), 64'(seen_fin), 64'd1);
    if (v.exp_fin >= 0) chk($sformatf("v%0d finish_cycle", vi), 64'(fin_cyc), 64'(v.exp_fin));
    chk($sformatf("v%0d err", vi), 64'(fin_err), 64'(v.exp_err));
    chk($sformatf("v%0d rd_count", vi), 64'(rd_n), 64'(v.exp_rd));
    chk($sformatf("v%0d wr_count", vi), 64'(wr_n), 64'(v.exp_wr));
    chk($sformatf("v%0d calc_count", vi), 64'(calc_n), 64'(v.exp_calc));
    chk($sformatf("v%0d rd_wr_overlap", vi), 64'(overlap_bad), 64'd0);
    chk($sformatf("v%0d busy_gap", vi), 64'(busy_bad), 64'd0);
    chk($sformatf("v%0d calc_order", vi), 64'(order_bad), 64'd0);
    rd_ready = 1'b1; wr_ready = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("v%0d idle_after", vi), 64'({busy, finish, err, rd_valid, wr_valid}), 64'd0);
`ifdef EC_SEQ_PERF_EN
    chk($sformatf("v%0d perf_cycles", vi), 64'(perf_cycles), 64'(fin_cyc));
`else
    chk($sformatf("v%0d perf_cycles", vi), 64'(perf_cycles), 64'd0);
`endif
  endtask

  initial begin
    int  n;
    bit  fin_in_reset;
    vecs[0]  = '{4, 2, 2, 32'h0000_1000, 32'h0000_8000, 1, 1'b0, 1'b0, 20, 1'b0, 8, 4, 2};
    vecs[1]  = '{0, 2, 2, 32'h0000_1000, 32'h0000_8000, 1, 1'b0, 1'b0, 2, 1'b1, 0, 0, 0};
    vecs[2]  = '{4, 5, 1, 32'h0000_1000, 32'h0000_8000, 1, 1'b0, 1'b0, 2, 1'b1, 0, 0, 0};
    vecs[3]  = '{3, 1, 0, 32'h0000_1000, 32'h0000_8000, 1, 1'b0, 1'b0, 2, 1'b0, 0, 0, 0};
    vecs[4]  = '{2, 1, 1, 32'hFFFF_FFC0, 32'h0000_0100, 3, 1'b0, 1'b0, 10, 1'b0, 2, 1, 1};
    vecs[5]  = '{8, 4, 3, 32'h0002_0000, 32'h0003_0000, 2, 1'b1, 1'b0, -1, 1'b0, 24, 12, 3};
    vecs[6]  = '{1, 1, 1, 32'h0000_0040, 32'h0000_0080, 1, 1'b0, 1'b1, 7, 1'b0, 1, 1, 1};
    vecs[7]  = '{9, 1, 1, 32'h0000_1000, 32'h0000_8000, 1, 1'b0, 1'b0, 2, 1'b1, 0, 0, 0};
    vecs[8]  = '{5, 3, 2, 32'hABCD_E000, 32'h1234_0000, 4, 1'b1, 1'b0, -1, 1'b0, 10, 6, 2};
    vecs[9]  = '{8, 4, 1, 32'h0000_0000, 32'hFFFF_FF80, 1, 1'b0, 1'b0, 17, 1'b0, 8, 4, 1};
    vecs[10] = '{2, 0, 1, 32'h0000_1000, 32'h0000_8000, 1, 1'b0, 1'b0, 2, 1'b1, 0, 0, 0};

    rst_n = 1'b0; start = 1'b0; rd_ready = 1'b0; wr_ready = 1'b0; calc_done = 1'b0;
    cfg_k = 4'd0; cfg_m = 3'd0; cfg_stripes = 16'd0;
    cfg_data_base = 32'd0; cfg_par_base = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({busy, finish, err, rd_valid, wr_valid, calc_start, rd_idx, wr_idx}), 64'd0);
    chk("reset_addr", 64'({rd_addr, wr_addr}), 64'd0);
    chk("reset_perf", 64'(perf_cycles), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_job(vecs[i], i);
    end

    // reset asserted while the engine is computing parity
    cfg_k = 4'd2; cfg_m = 3'd1; cfg_stripes = 16'd1;
    cfg_data_base = 32'h0000_2000; cfg_par_base = 32'h0000_9000;
    start = 1'b1; rd_ready = 1'b1; wr_ready = 1'b1; calc_done = 1'b0;
    n = 0;
    @(posedge clk); #1;
    start = 1'b0;
    while (!calc_start && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_job_calc_start_seen", 64'(calc_start), 64'd1);
    @(posedge clk); #1;
    chk("rst_job_busy_in_wait", 64'({busy, rd_valid, wr_valid}), 64'b100);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", 64'({busy, finish, err, rd_valid, wr_valid, calc_start, rd_idx, wr_idx}), 64'd0);
    chk("rst_mid_addr", 64'({rd_addr, wr_addr}), 64'd0);
    chk("rst_mid_perf", 64'(perf_cycles), 64'd0);
    fin_in_reset = 0;
    calc_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (finish) fin_in_reset = 1;
    end
    calc_done = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (finish) fin_in_reset = 1;
    chk("rst_no_finish", 64'(fin_in_reset), 64'd0);
    run_job(vecs[0], 100);
    run_job(vecs[4], 104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ec_stripe_sequencer.md
# ec_stripe_sequencer

Job controller for the erasure-coding datapath. Accepts one encode job (K data chunks + M parity chunks per stripe, N stripes), then drives the engine in order per stripe: chunk read requests, one parity calculation, parity write requests. Sits between the host-side `start`/`finish` job interface and the encode engine. Owns all chunk address generation.

## Interface
Parameters:
- `K_MAX`, 8, maximum data chunks per stripe
- `M_MAX`, 4, maximum parity chunks per stripe
- `ADDR_W`, 32, byte address width
- `CHUNK_BYTES`, 64, chunk size in bytes (power of two)
- `STRIPE_W`, 16, stripe count width

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  job request, sampled only in IDLE
- `cfg_k`  in  $clog2(K_MAX+1)  data chunks per stripe
- `cfg_m`  in  $clog2(M_MAX+1)  parity chunks per stripe
- `cfg_stripes`  in  STRIPE_W  stripe count
- `cfg_data_base`, `cfg_par_base`  in  ADDR_W  base addresses
- `busy`  out  1  high from accept to finish
- `finish`  out  1  one-cycle job-end pulse
- `err`  out  1  one-cycle pulse with `finish` on an illegal config
- `rd_valid` / `rd_ready`  out/in  1  chunk read handshake
- `rd_addr`  out  ADDR_W; `rd_idx`  out  $clog2(K_MAX)  chunk index in stripe
- `calc_start`  out  1  one-cycle pulse; `calc_done`  in  1  engine completion
- `wr_valid` / `wr_ready`  out/in  1  parity write handshake
- `wr_addr`  out  ADDR_W; `wr_idx`  out  $clog2(M_MAX)  parity index
- `perf_cycles`  out  32  job cycle count (see Configuration)

## Operation
- States: IDLE, CHECK, LOAD, CALC, WAIT, STORE, NEXT, DONE.
- IDLE: `start`=1 latches all `cfg_*` and goes to CHECK. `start` in any other state is ignored.
- CHECK: `cfg_k`∈[1,K_MAX] and `cfg_m`∈[1,M_MAX] are required, otherwise go to DONE with `err`. `cfg_stripes`==0 goes to DONE with no `err` and no requests. Any other config goes to LOAD.
- LOAD: present chunks i=0..k-1. Each chunk advances on `rd_valid&rd_ready`. The last chunk goes to CALC.
- CALC: `calc_start` high for exactly one cycle, then WAIT.
- WAIT: hold until `calc_done`=1. A `calc_done` outside WAIT is ignored.
- STORE: present parity j=0..m-1 on `wr_*`. The last handshake goes to NEXT.
- NEXT: stripe counter +1. If it equals `cfg_stripes`, go to DONE, else go to LOAD.
- DONE: `finish`=1 for one cycle, then IDLE.
- Address arithmetic (mod 2^ADDR_W, wrap silently):
  - `rd_addr` = data_base + (s·k + i)·CHUNK_BYTES
  - `wr_addr` = par_base + (s·m + j)·CHUNK_BYTES
  - Both are running pointers incremented by CHUNK_BYTES per handshake. No multiplier.
- `rd_addr`/`rd_idx` and `wr_addr`/`wr_idx` stay stable while valid is high and ready is low. Valid never drops without a handshake.

## Timing
- Reset values: all outputs 0, state IDLE.
- `start` at cycle 0 → CHECK at cycle 1 → first `rd_valid` at cycle 2.
- Illegal config or zero stripes: `finish` at cycle 2.
- Per stripe with ready tied high: k + 1 (CALC) + W (wait, ≥1) + m + 1 (NEXT) cycles.
- `finish` comes 2 cycles after the final write handshake (NEXT, then DONE).
- `rd_valid` and `wr_valid` are registered and never asserted together.
- If `rst_n` falls mid-job, everything returns to reset values immediately. No `finish` is issued.

## Configuration
- `EC_SEQ_PERF_EN` defined:
  - `perf_cycles` clears on accept and increments every cycle while `busy`.
  - It holds its value after `finish` until the next accept.
- `EC_SEQ_PERF_EN` undefined: `perf_cycles` tied to 0 and no counter is built.

## Structure
- `ec_seq_pkg` holds the state enum, the `ec_job_cfg_t` struct (k, m, stripes, bases) and the CHUNK_BYTES default.
- Sub-module `ec_addr_ptr` is one running address pointer with load, increment and value. It is instantiated twice, once for read and once for write.

## Test plan
- k=4, m=2, stripes=2, data_base=0x1000, par_base=0x8000, readies high:
  - `rd_addr` goes 0x1000..0x10C0 then 0x1100..0x11C0.
  - `wr_addr` goes 0x8000, 0x8040, 0x8080, 0x80C0.
  - 2 `calc_start` pulses, a single `finish`.
- Random `rd_ready`/`wr_ready` stalls: address and index stay stable through every stall, no lost or duplicated handshake.
- cfg_k=0 or cfg_m=5: `finish` and `err` both high at cycle 2, no `rd_valid`.
- stripes=0: `finish` at cycle 2, `err`=0.
- data_base=0xFFFFFFC0, k=2: `rd_addr` goes 0xFFFFFFC0 then 0x00000000.
- `rst_n` low during WAIT, then `start` again: the new job starts cleanly. With the macro defined, `perf_cycles` matches the cycle count from accept to `finish`.
